uart_rx: RTL and testbench

UART receiver, 8N1, LSB first: the receive-side counterpart of the monitoring link's transmitter. It sits between the asynchronous `inputRx` pin and the monitoring/command logic. It resynchronises the line, detects and qualifies start bits, samples each bit at mid-bit, and presents each received byte with a one-cycle `doneRx` strobe. Framing faults are flagged and never delivered as data.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, default bit
// period and the mid-bit offset used to qualify start bits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    BREAK   = 3'd5
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEFAULT = 870;

  // Offset from start-bit entry to the middle of the start bit.
  function automatic logic [15:0] half_count(input int clks_per_bit);
    return 16'((clks_per_bit - 1) / 2);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input, with a
// selectable reset value so idle-high lines come out of reset idle.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= RESET_VALUE;
      sync_out <= RESET_VALUE;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle done/frame-error
// strobes; a low stop bit parks the FSM until the line returns high.
//
//   state   | meaning
//   IDLE    | line idle, waiting for a falling edge
//   START   | counting to mid start bit, rejecting glitches
//   DATA    | sampling 8 data bits at mid-bit
//   STOP    | sampling the stop bit
//   CLEANUP | one cycle gap before re-arming
//   BREAK   | stop bit was low, wait for line high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inputRx,
  output logic [7:0] outputRxByte,
  output logic       doneRx,
  output logic       isRxActive,
  output logic       frameError
);

  localparam logic [15:0] HALF = half_count(CLKS_PER_BIT);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic        rx_sync;
  rx_state_t   state, state_n;
  logic [15:0] clock_count, count_n;
  logic [2:0]  bit_index, index_n;
  logic [7:0]  shift_reg, shift_n;
  logic [7:0]  byte_n;
  logic        done_n, ferr_n, active_n;

  uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (inputRx),
    .sync_out (rx_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      clock_count  <= '0;
      bit_index    <= '0;
      shift_reg    <= '0;
      outputRxByte <= '0;
      doneRx       <= 1'b0;
      frameError   <= 1'b0;
      isRxActive   <= 1'b0;
    end else begin
      state        <= state_n;
      clock_count  <= count_n;
      bit_index    <= index_n;
      shift_reg    <= shift_n;
      outputRxByte <= byte_n;
      doneRx       <= done_n;
      frameError   <= ferr_n;
      isRxActive   <= active_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = clock_count + 16'd1;
    index_n  = bit_index;
    shift_n  = shift_reg;
    byte_n   = outputRxByte;
    done_n   = 1'b0;
    ferr_n   = 1'b0;
    active_n = isRxActive;
    case (state)
      IDLE: begin
        count_n  = '0;
        index_n  = '0;
        active_n = 1'b0;
        if (!rx_sync) state_n = START;
      end
      START: begin
        if (clock_count == HALF) begin
          count_n = '0;
          if (!rx_sync) begin
            state_n  = DATA;
            active_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (clock_count == LAST) begin
          count_n            = '0;
          shift_n[bit_index] = rx_sync;
          if (bit_index == 3'd7) state_n = STOP;
          else                   index_n = bit_index + 3'd1;
        end
      end
      STOP: begin
        if (clock_count == LAST) begin
          count_n  = '0;
          active_n = 1'b0;
          if (rx_sync) begin
            byte_n  = shift_reg;
            done_n  = 1'b1;
            state_n = CLEANUP;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      CLEANUP: begin
        count_n  = '0;
        active_n = 1'b0;
        state_n  = IDLE;
      end
      BREAK: begin
        count_n  = '0;
        active_n = 1'b0;
        if (rx_sync) state_n = IDLE;
      end
      default: begin
        count_n  = '0;
        active_n = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: framing, glitch rejection,
// framing errors, mid-frame reset, back-to-back frames and skewed loopback.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB    = 16;
  localparam int BIT_NS = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] outputRxByte;
  logic       doneRx, isRxActive, frameError;

  int tests_run = 0;
  int tests_failed = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         active_seen = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .inputRx      (rx_pin),
    .outputRxByte (outputRxByte),
    .doneRx       (doneRx),
    .isRxActive   (isRxActive),
    .frameError   (frameError)
  );

  always @(negedge clk) begin
    if (doneRx) begin
      done_cnt++;
      rx_q.push_back(outputRxByte);
    end
    if (frameError) ferr_cnt++;
    if (doneRx && frameError) both_cnt++;
    if (isRxActive) active_seen++;
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns);
    rx_pin = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      #(bit_ns);
    end
    rx_pin = stop;
    #(bit_ns);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_cycles(3);
    tests_run++;
    if (outputRxByte !== 8'h00) begin tests_failed++; $display("FAIL reset_byte got %h exp 00", outputRxByte); end
    tests_run++;
    if (doneRx !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", doneRx); end
    tests_run++;
    if (isRxActive !== 1'b0) begin tests_failed++; $display("FAIL reset_active got %b exp 0", isRxActive); end
    tests_run++;
    if (frameError !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr got %b exp 0", frameError); end
    reset = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_two_bytes;
    int d0, f0;
    logic [7:0] got;
    rx_q.delete();
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, BIT_NS);
    idle_cycles(2 * CPB);
    send_frame(8'hA3, 1'b1, BIT_NS);
    idle_cycles(2 * CPB);
    tests_run++;
    if (done_cnt - d0 !== 2) begin tests_failed++; $display("FAIL two_done_count got %0d exp 2", done_cnt - d0); end
    got = 8'hxx; if (rx_q.size() > 0) got = rx_q.pop_front();
    tests_run++;
    if (got !== 8'h55) begin tests_failed++; $display("FAIL two_first_byte got %h exp 55", got); end
    got = 8'hxx; if (rx_q.size() > 0) got = rx_q.pop_front();
    tests_run++;
    if (got !== 8'hA3) begin tests_failed++; $display("FAIL two_second_byte got %h exp a3", got); end
    tests_run++;
    if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL two_ferr got %0d exp 0", ferr_cnt - f0); end
  endtask

  task automatic test_glitch;
    int d0, a0;
    d0 = done_cnt; a0 = active_seen;
    rx_pin = 1'b0;
    idle_cycles(5);
    rx_pin = 1'b1;
    idle_cycles(7);
    tests_run++;
    if (dut.state !== IDLE) begin tests_failed++; $display("FAIL glitch_idle got %0d exp %0d", dut.state, IDLE); end
    idle_cycles(2 * CPB);
    tests_run++;
    if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL glitch_done got %0d exp 0", done_cnt - d0); end
    tests_run++;
    if (active_seen - a0 !== 0) begin tests_failed++; $display("FAIL glitch_active got %0d exp 0", active_seen - a0); end
  endtask

  task automatic test_frame_error;
    int d0, f0;
    logic [7:0] got;
    rx_q.delete();
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, BIT_NS);
    idle_cycles(40);
    rx_pin = 1'b1;
    idle_cycles(2 * CPB);
    tests_run++;
    if (ferr_cnt - f0 !== 1) begin tests_failed++; $display("FAIL ferr_count got %0d exp 1", ferr_cnt - f0); end
    tests_run++;
    if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL ferr_done got %0d exp 0", done_cnt - d0); end
    tests_run++;
    if (outputRxByte !== 8'hA3) begin tests_failed++; $display("FAIL ferr_byte_held got %h exp a3", outputRxByte); end
    send_frame(8'h81, 1'b1, BIT_NS);
    idle_cycles(2 * CPB);
    tests_run++;
    if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL ferr_recover_done got %0d exp 1", done_cnt - d0); end
    got = 8'hxx; if (rx_q.size() > 0) got = rx_q.pop_front();
    tests_run++;
    if (got !== 8'h81) begin tests_failed++; $display("FAIL ferr_recover_byte got %h exp 81", got); end
    tests_run++;
    if (ferr_cnt - f0 !== 1) begin tests_failed++; $display("FAIL ferr_no_repeat got %0d exp 1", ferr_cnt - f0); end
  endtask

  task automatic test_reset_midframe;
    int d0, f0;
    logic [7:0] got;
    rx_q.delete();
    d0 = done_cnt; f0 = ferr_cnt;
    fork
      send_frame(8'hF3, 1'b1, BIT_NS);
      begin
        idle_cycles(88);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        tests_run++;
        if (outputRxByte !== 8'h00) begin tests_failed++; $display("FAIL midrst_byte got %h exp 00", outputRxByte); end
        tests_run++;
        if (isRxActive !== 1'b0) begin tests_failed++; $display("FAIL midrst_active got %b exp 0", isRxActive); end
        tests_run++;
        if (doneRx !== 1'b0 || frameError !== 1'b0) begin
          tests_failed++; $display("FAIL midrst_pulses got done=%b ferr=%b exp 0 0", doneRx, frameError);
        end
      end
    join
    idle_cycles(2 * CPB);
    tests_run++;
    if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
      tests_failed++; $display("FAIL midrst_tail got done=%0d ferr=%0d exp 0 0", done_cnt - d0, ferr_cnt - f0);
    end
    send_frame(8'hFF, 1'b1, BIT_NS);
    idle_cycles(2 * CPB);
    got = 8'hxx; if (rx_q.size() > 0) got = rx_q.pop_front();
    tests_run++;
    if (got !== 8'hFF || done_cnt - d0 !== 1) begin
      tests_failed++; $display("FAIL midrst_next got %h count %0d exp ff count 1", got, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    logic [7:0] got;
    rx_q.delete();
    d0 = done_cnt;
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    idle_cycles(2 * CPB);
    tests_run++;
    if (done_cnt - d0 !== 2) begin tests_failed++; $display("FAIL b2b_count got %0d exp 2", done_cnt - d0); end
    got = 8'hxx; if (rx_q.size() > 0) got = rx_q.pop_front();
    tests_run++;
    if (got !== 8'h00) begin tests_failed++; $display("FAIL b2b_first got %h exp 00", got); end
    got = 8'hxx; if (rx_q.size() > 0) got = rx_q.pop_front();
    tests_run++;
    if (got !== 8'hFF) begin tests_failed++; $display("FAIL b2b_second got %h exp ff", got); end
  endtask

  task automatic test_loopback_skew;
    int f0, bit_ns;
    logic [7:0] d, got;
    rx_q.delete();
    f0 = ferr_cnt;
    for (int i = 0; i < 256; i++) begin
      bit_ns = (i % 2 == 1) ? 155 : 165;
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b1, bit_ns);
      #(bit_ns);
      got = 8'hxx; if (rx_q.size() > 0) got = rx_q.pop_front();
      tests_run++;
      if (got !== d) begin tests_failed++; $display("FAIL loop_byte_%0d got %h exp %h", i, got, d); end
    end
    idle_cycles(2 * CPB);
    tests_run++;
    if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL loop_ferr got %0d exp 0", ferr_cnt - f0); end
    tests_run++;
    if (rx_q.size() !== 0) begin tests_failed++; $display("FAIL loop_extra got %0d exp 0", rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_back_to_back();
    test_loopback_skew();
    tests_run++;
    if (both_cnt !== 0) begin tests_failed++; $display("FAIL done_and_ferr_overlap got %0d exp 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
